// File: rtl/tx_axis_arbiter_if.sv
// AXIS bundle between N_SRC packet sources, the TX arbiter and tx_mac.
// master: arbiter view (drives m00 and per-source tready); slave: environment view.
interface tx_axis_arbiter_if #(
  parameter int N_SRC = 4
);
  logic [N_SRC*32-1:0] s00_axis_tdata;
  logic [N_SRC*4-1:0]  s00_axis_tkeep;
  logic [N_SRC-1:0]    s00_axis_tvalid;
  logic [N_SRC-1:0]    s00_axis_tlast;
  logic [N_SRC-1:0]    s00_axis_tready;
  logic [31:0]         m00_axis_tdata;
  logic [3:0]          m00_axis_tkeep;
  logic                m00_axis_tvalid;
  logic                m00_axis_tlast;
  logic                m00_axis_tready;

  modport master (
    input  s00_axis_tdata, s00_axis_tkeep, s00_axis_tvalid, s00_axis_tlast,
    output s00_axis_tready,
    output m00_axis_tdata, m00_axis_tkeep, m00_axis_tvalid, m00_axis_tlast,
    input  m00_axis_tready
  );

  modport slave (
    output s00_axis_tdata, s00_axis_tkeep, s00_axis_tvalid, s00_axis_tlast,
    input  s00_axis_tready,
    input  m00_axis_tdata, m00_axis_tkeep, m00_axis_tvalid, m00_axis_tlast,
    output m00_axis_tready
  );
endinterface

// File: rtl/tx_axis_arbiter.sv
// Packet-granular round-robin arbiter feeding tx_mac from N_SRC AXIS sources.
// Optional TX_ARB_FAST_REGRANT_EN: regrant on the TLAST-accept edge, no idle bubble.
//
// state  | meaning
// IDLE   | no grant, all outputs 0; arbitrate from rr_ptr on any tvalid
// ACTIVE | one source granted until its TLAST beat is accepted
module tx_axis_arbiter #(
  parameter int N_SRC = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  tx_axis_arbiter_if.master bus,
  output logic [N_SRC-1:0]  o_grant,
  output logic              o_busy
);
  localparam int DATA_WIDTH  = 32;
  localparam int DATA_NBYTES = DATA_WIDTH / 8;
  localparam int IDX_W       = $clog2(N_SRC);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01
  } state_t;

  state_t             state, next_state;
  logic [IDX_W-1:0]   gidx, next_gidx;
  logic [IDX_W-1:0]   rr_ptr, next_ptr;
  logic [IDX_W-1:0]   search_base, winner;
  logic [N_SRC-1:0]   next_grant;
  logic               any_req;
  logic               last_accept;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int ofs);
    int s;
    s = int'(base) + ofs;
    if (s >= N_SRC) s = s - N_SRC;
    return IDX_W'(s);
  endfunction

`ifdef TX_ARB_FAST_REGRANT_EN
  // Searching from g+1 visits g last, so g only wins when it is the sole requester.
  assign search_base = (state == ACTIVE) ? wrap_add(gidx, 1) : rr_ptr;
`else
  assign search_base = rr_ptr;
`endif

  // Descending scan so the smallest offset from search_base is the final winner.
  always_comb begin
    any_req = 1'b0;
    winner  = search_base;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (bus.s00_axis_tvalid[wrap_add(search_base, i)]) begin
        any_req = 1'b1;
        winner  = wrap_add(search_base, i);
      end
    end
  end

  always_comb begin
    bus.m00_axis_tdata  = '0;
    bus.m00_axis_tkeep  = '0;
    bus.m00_axis_tvalid = 1'b0;
    bus.m00_axis_tlast  = 1'b0;
    bus.s00_axis_tready = '0;
    if (state == ACTIVE) begin
      bus.m00_axis_tdata  = bus.s00_axis_tdata[gidx*DATA_WIDTH +: DATA_WIDTH];
      bus.m00_axis_tkeep  = bus.s00_axis_tkeep[gidx*DATA_NBYTES +: DATA_NBYTES];
      bus.m00_axis_tvalid = bus.s00_axis_tvalid[gidx];
      bus.m00_axis_tlast  = bus.s00_axis_tlast[gidx];
      bus.s00_axis_tready[gidx] = bus.m00_axis_tready;
    end
  end

  assign last_accept = (state == ACTIVE) && bus.m00_axis_tvalid &&
                       bus.m00_axis_tready && bus.m00_axis_tlast;
  assign o_busy      = (state == ACTIVE);

  always_comb begin
    next_state = state;
    next_gidx  = gidx;
    next_ptr   = rr_ptr;
    next_grant = o_grant;
    case (state)
      IDLE: begin
        if (any_req) begin
          next_state = ACTIVE;
          next_gidx  = winner;
          next_grant = {{(N_SRC-1){1'b0}}, 1'b1} << winner;
        end
      end
      ACTIVE: begin
        if (last_accept) begin
          next_ptr = wrap_add(gidx, 1);
`ifdef TX_ARB_FAST_REGRANT_EN
          if (any_req) begin
            next_gidx  = winner;
            next_grant = {{(N_SRC-1){1'b0}}, 1'b1} << winner;
          end else begin
            next_state = IDLE;
            next_grant = '0;
          end
`else
          next_state = IDLE;
          next_grant = '0;
`endif
        end
      end
      default: begin
        next_state = IDLE;
        next_grant = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state   <= IDLE;
      gidx    <= '0;
      rr_ptr  <= '0;
      o_grant <= '0;
    end else begin
      state   <= next_state;
      gidx    <= next_gidx;
      rr_ptr  <= next_ptr;
      o_grant <= next_grant;
    end
  end
endmodule

// File: tb/tb_tx_axis_arbiter.sv
// Directed, table-driven bench for tx_axis_arbiter (default build, 4 sources).
// Hand-written sequences cover async reset mid-packet and back-to-back single beats.
module tb_tx_axis_arbiter;
  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] grant;
  logic         busy;

  tx_axis_arbiter_if #(.N_SRC(N)) bus ();

  tx_axis_arbiter #(.N_SRC(N)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus),
    .o_grant (grant),
    .o_busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [3:0] tvalid;
    logic [3:0] tlast;
    logic       mready;
    logic [3:0] keep;
    logic [3:0] e_grant;
    logic       e_busy;
    logic       e_mvalid;
    logic       e_mlast;
    logic [3:0] e_tready;
  } vec_t;

  vec_t vq[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic add(input logic r, input logic [3:0] tv, input logic [3:0] tl,
                     input logic mr, input logic [3:0] kp, input logic [3:0] eg,
                     input logic eb, input logic emv, input logic eml,
                     input logic [3:0] etr);
    vec_t v;
    v = '{r, tv, tl, mr, kp, eg, eb, emv, eml, etr};
    vq.push_back(v);
  endtask

  task automatic add_idle(input logic r, input logic [3:0] tv, input logic [3:0] tl);
    add(r, tv, tl, 1'b1, 4'hF, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] src_data(input int k, input int idx);
    return {4'(k), 12'h000, 16'(idx)};
  endfunction

  function automatic logic [31:0] exp_data(input logic [3:0] g, input int idx);
    logic [31:0] d;
    d = '0;
    for (int k = 0; k < N; k++)
      if (g == 4'(1 << k)) d = src_data(k, idx);
    return d;
  endfunction

  task automatic drive(input logic [3:0] tv, input logic [3:0] tl, input logic mr,
                       input logic [3:0] kp, input int idx);
    bus.s00_axis_tvalid = tv;
    bus.s00_axis_tlast  = tl;
    bus.m00_axis_tready = mr;
    for (int k = 0; k < N; k++) begin
      bus.s00_axis_tdata[k*32 +: 32] = src_data(k, idx);
      bus.s00_axis_tkeep[k*4 +: 4]   = kp;
    end
  endtask

  function automatic logic [63:0] observed();
    return {17'd0, grant, busy, bus.m00_axis_tvalid, bus.m00_axis_tlast,
            bus.s00_axis_tready, bus.m00_axis_tkeep, bus.m00_axis_tdata};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] exp;
    int hs_cnt, idle_cnt, bad_grant;

    // test 1: src1 alone, 5 beats, distinct tkeep on the last beat
    add_idle(0, 4'b0010, 4'b0000);
    for (int i = 0; i < 4; i++) add(0, 4'b0010, 4'b0000, 1, 4'hF, 4'b0010, 1, 1, 0, 4'b0010);
    add(0, 4'b0010, 4'b0010, 1, 4'h3, 4'b0010, 1, 1, 1, 4'b0010);
    add_idle(0, 4'b0000, 4'b0000);
    // test 2: reset the pointer, then all four request 2-beat packets
    add_idle(1, 4'b1111, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      add_idle(0, 4'b1111, 4'b0000);
      add(0, 4'b1111, 4'b0000, 1, 4'hF, 4'(1 << k), 1, 1, 0, 4'(1 << k));
      add(0, 4'b1111, 4'b1111, 1, 4'hF, 4'(1 << k), 1, 1, 1, 4'(1 << k));
    end
    add_idle(0, 4'b1111, 4'b0000);
    add(0, 4'b1111, 4'b0000, 1, 4'hF, 4'b0001, 1, 1, 0, 4'b0001);
    add(0, 4'b0001, 4'b0001, 1, 4'hF, 4'b0001, 1, 1, 1, 4'b0001);
    // test 3: src2 stalls mid-packet while src0 requests
    add_idle(0, 4'b0100, 4'b0000);
    add(0, 4'b0100, 4'b0000, 1, 4'hF, 4'b0100, 1, 1, 0, 4'b0100);
    for (int i = 0; i < 3; i++) add(0, 4'b0001, 4'b0000, 1, 4'hF, 4'b0100, 1, 0, 0, 4'b0100);
    add(0, 4'b0101, 4'b0100, 1, 4'hF, 4'b0100, 1, 1, 1, 4'b0100);
    add_idle(0, 4'b0001, 4'b0000);
    add(0, 4'b0001, 4'b0001, 1, 4'hF, 4'b0001, 1, 1, 1, 4'b0001);
    // test 4: src3 TLAST held off by tready=0 for 4 cycles
    add_idle(0, 4'b1000, 4'b0000);
    for (int i = 0; i < 4; i++) add(0, 4'b1000, 4'b1000, 0, 4'hF, 4'b1000, 1, 1, 1, 4'b0000);
    add(0, 4'b1000, 4'b1000, 1, 4'hF, 4'b1000, 1, 1, 1, 4'b1000);
    add_idle(0, 4'b0000, 4'b0000);
    // move rr_ptr to 2 so the reset test can show it returns to 0
    add_idle(0, 4'b0010, 4'b0000);
    add(0, 4'b0010, 4'b0010, 1, 4'hF, 4'b0010, 1, 1, 1, 4'b0010);
    add_idle(0, 4'b0000, 4'b0000);

    rst = 1'b1;
    drive(4'b0000, 4'b0000, 1'b1, 4'hF, 0);
    repeat (2) @(negedge clk);

    foreach (vq[i]) begin
      @(negedge clk);
      rst = vq[i].rst;
      drive(vq[i].tvalid, vq[i].tlast, vq[i].mready, vq[i].keep, i);
      #1;
      exp = {17'd0, vq[i].e_grant, vq[i].e_busy, vq[i].e_mvalid, vq[i].e_mlast,
             vq[i].e_tready, (vq[i].e_grant != 0) ? vq[i].keep : 4'h0,
             exp_data(vq[i].e_grant, i)};
      check($sformatf("vec%0d", i), observed(), exp);
    end

    // test 5: asynchronous reset on beat 3 of a src3 packet
    @(negedge clk);
    drive(4'b1000, 4'b0000, 1'b1, 4'hF, 100);
    #1 check("rst_pre_idle", {60'd0, grant}, 64'd0);
    @(negedge clk);
    #1 check("rst_beat1_grant", {60'd0, grant}, 64'b1000);
    @(negedge clk);
    @(negedge clk);
    #1 check("rst_beat3_valid", {62'd0, grant[3], bus.m00_axis_tvalid}, 64'b11);
    #2 rst = 1'b1;
    #1 check("rst_async_clear",
             {54'd0, grant, busy, bus.m00_axis_tvalid, bus.s00_axis_tready}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(4'b1111, 4'b0000, 1'b1, 4'hF, 101);
    #1 check("rst_post_idle", {60'd0, grant}, 64'd0);
    @(negedge clk);
    #1 check("rst_regrant_src0", {60'd0, grant}, 64'b0001);

    // test 6: src0 sends single-beat packets back to back
    hs_cnt = 0;
    idle_cnt = 0;
    bad_grant = 0;
    for (int c = 0; c < 12; c++) begin
      if (c != 0) @(negedge clk);
      drive(4'b0001, 4'b0001, 1'b1, 4'hF, 200 + c);
      #1;
      if (bus.m00_axis_tvalid && bus.m00_axis_tready && bus.m00_axis_tlast) begin
        hs_cnt++;
        if (grant != 4'b0001) bad_grant++;
      end
      if (grant == 4'b0000) idle_cnt++;
    end
    check("b2b_handshakes", 64'(hs_cnt), 64'd6);
    check("b2b_idle_cycles", 64'(idle_cnt), 64'd6);
    check("b2b_grant_src0", 64'(bad_grant), 64'd0);

    drive(4'b0000, 4'b0000, 1'b1, 4'hF, 0);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
